mygo_chan_arbiter: RTL

- Merges NREQ producer process write ports onto the single write side of one channel FIFO (mygo_fifo_* family).
- Implements Go channels with multiple senders.
- Sits between the compiled process FSMs and the FIFO instance in the generated top.
- Round-robin fair, one registered output slot, full throughput of one word per cycle.

---
 rtl/mygo_chan_pkg.sv | 37 +++
 rtl/mygo_rr_pick.sv | 50 +++++
 rtl/mygo_chan_arbiter.sv | 90 +++++++++
 3 files changed

// File: rtl/mygo_chan_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mygo_chan_pkg
// Brief    : Shared types and helpers for the mygo channel write-side blocks.
// Revision : 1.0
// ============================================================================
package mygo_chan_pkg;

    localparam int CHAN_WIDTH_DEFAULT = 32;
    localparam int NREQ_DEFAULT       = 4;

    // Never returns less than 1 so index ports keep a legal width.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int IDW_DEFAULT = clog2(NREQ_DEFAULT);

    typedef struct packed {
        logic [CHAN_WIDTH_DEFAULT-1:0] data;
        logic                          valid;
    } chan_wr_t;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/mygo_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : mygo_rr_pick
// Brief    : Combinational round-robin picker: rotate, priority-encode, rotate back.
// Revision : 1.0
// ============================================================================
module mygo_rr_pick
    import mygo_chan_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_idx,
    output logic            o_any
);

    localparam logic [IDW:0] c_NREQ_EXT = (IDW+1)'(NREQ);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IDW-1:0]    w_off;
    logic [IDW:0]      w_sum;

    always_comb begin
        // Doubling the vector makes the rotate work for non-power-of-two NREQ.
        w_dbl = {i_req, i_req} >> i_ptr;
        w_rot = w_dbl[NREQ-1:0];
        w_off = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
            end
        end
        o_any = |i_req;
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= c_NREQ_EXT) begin
            w_sum = w_sum - c_NREQ_EXT;
        end
        o_grant_idx = w_sum[IDW-1:0];
        o_grant     = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_grant[i] = o_any && (o_grant_idx == IDW'(i));
        end
    end

endmodule
`default_nettype wire

// File: rtl/mygo_chan_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mygo_chan_arbiter
// Brief    : Round-robin merge of NREQ channel senders into one registered write slot.
// Revision : 1.0
// ============================================================================
module mygo_chan_arbiter
    import mygo_chan_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4,
    parameter int IDW   = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    input  logic [NREQ-1:0]       req_wvalid,
    output logic [NREQ-1:0]       req_wready,
    output logic [WIDTH-1:0]      out_wdata,
    output logic                  out_wvalid,
    input  logic                  out_wready,
    output logic [IDW-1:0]        out_id,
    output logic                  busy
);

    localparam logic [IDW-1:0] c_LAST_IDX = IDW'(NREQ - 1);

    slot_state_t       state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_grant_idx;
    logic              w_any;
    logic              w_can_accept;
    logic              w_accept;

    mygo_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req       (req_wvalid),
        .i_ptr       (rr_ptr_q),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    always_comb begin
        w_can_accept = (state_q == SLOT_EMPTY) || out_wready;
        // Holding off grants during reset keeps producers from losing a word.
        w_accept     = w_can_accept && w_any && rst;
        req_wready   = w_accept ? w_grant : '0;

        state_d  = state_q;
        data_d   = data_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        if (w_accept) begin
            state_d  = SLOT_FULL;
            data_d   = req_wdata[int'(w_grant_idx)*WIDTH +: WIDTH];
            id_d     = w_grant_idx;
            rr_ptr_d = (w_grant_idx == c_LAST_IDX) ? '0 : w_grant_idx + IDW'(1);
        end else if ((state_q == SLOT_FULL) && out_wready) begin
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SLOT_EMPTY;
            data_q   <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign out_wvalid = (state_q == SLOT_FULL);
    assign out_wdata  = data_q;
    assign out_id     = id_q;
    assign busy       = out_wvalid || (|req_wvalid);

endmodule
`default_nettype wire
